// File: rtl/cpu_phase_controller.sv
// Four-phase multicycle sequencer: FETCH, DECODE, EXECUTE, WRITEBACK.
// Issues on a synchronized step edge or on a run-mode timer.
module cpu_phase_controller #(
  parameter int          RUN_DIV = 25000000,
  parameter logic [3:0]  HALT_OP = 4'hF,
  parameter logic [15:0] WB_MASK = 16'h00FF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step_in,
  input  logic        run,
  input  logic [3:0]  codop,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        exec_en,
  output logic        wb_en,
  output logic        reg_we,
  output logic        busy,
  output logic        halted,
  output logic [2:0]  phase,
  output logic [15:0] instr_count
);

  localparam int TW =
    (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [TW-1:0] RELOAD =
    TW'(RUN_DIV - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    WRITEBACK = 3'd4,
    HALTED    = 3'd5
  } state_t;

  state_t          state;
  logic            s1, s2, s3;
  logic            step_pulse;
  logic [TW-1:0]   timer;
  logic [3:0]      op_q;
  logic [15:0]     count_q;

  assign step_pulse = s2 & ~s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      timer   <= RELOAD;
      op_q    <= 4'h0;
      count_q <= 16'h0000;
    end else begin
      s1 <= step_in;
      s2 <= s1;
      s3 <= s2;
      unique case (state)
        IDLE: begin
          if (!run)
            timer <= RELOAD;
          else if (timer != '0)
            timer <= timer - 1'b1;
          if (step_pulse || (run && timer == '0))
            state <= FETCH;
        end
        FETCH:
          state <= DECODE;
        DECODE: begin
          op_q  <= codop;
          state <= EXECUTE;
        end
        EXECUTE:
          state <= (op_q == HALT_OP) ?
                   HALTED : WRITEBACK;
        WRITEBACK: begin
          count_q <= count_q + 16'd1;
          timer   <= RELOAD;
          state   <= IDLE;
        end
        HALTED:
          state <= HALTED;
        default:
          state <= IDLE;
      endcase
    end
  end

  assign fetch_en    = (state == FETCH);
  assign decode_en   = (state == DECODE);
  assign exec_en     = (state == EXECUTE);
  assign wb_en       = (state == WRITEBACK);
  assign reg_we      = wb_en & WB_MASK[op_q];
  assign busy        = fetch_en | decode_en |
                       exec_en | wb_en;
  assign halted      = (state == HALTED);
  assign phase       = state;
  assign instr_count = count_q;

endmodule

// File: tb/tb_cpu_phase_controller.sv
// Directed bench for cpu_phase_controller.
// Small RUN_DIV keeps run-mode cases short.
module tb_cpu_phase_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        step_in;
  logic        run;
  logic [3:0]  codop;
  logic        fetch_en, decode_en;
  logic        exec_en, wb_en;
  logic        reg_we, busy, halted;
  logic [2:0]  phase;
  logic [15:0] instr_count;

  int errors = 0;
  int checks = 0;
  int fetch_cnt = 0;
  int wb_cnt = 0;
  int we_cnt = 0;

  cpu_phase_controller #(
    .RUN_DIV(4),
    .HALT_OP(4'hF),
    .WB_MASK(16'h00FF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .step_in(step_in),
    .run(run),
    .codop(codop),
    .fetch_en(fetch_en),
    .decode_en(decode_en),
    .exec_en(exec_en),
    .wb_en(wb_en),
    .reg_we(reg_we),
    .busy(busy),
    .halted(halted),
    .phase(phase),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fetch_en) fetch_cnt++;
    if (wb_en)    wb_cnt++;
    if (reg_we)   we_cnt++;
  end

  task automatic do_reset();
    rst = 1'b1;
    step_in = 1'b0;
    run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    fetch_cnt = 0;
    wb_cnt = 0;
    we_cnt = 0;
    rst = 1'b0;
  endtask

  task automatic pulse_step();
    @(negedge clk);
    step_in = 1'b1;
    @(negedge clk);
    step_in = 1'b0;
  endtask

  task automatic wait_fetch(
    input string name
  );
    bit seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fetch_en) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: no fetch_en within 10 cycles",
               name);
    end
  endtask

  task automatic test_reset();
    codop = 4'h1;
    do_reset();
    checks++;
    if ({fetch_en, decode_en, exec_en, wb_en,
         reg_we, busy, halted} !== 7'b0 ||
        phase !== 3'd0 ||
        instr_count !== 16'h0) begin
      errors++;
      $display("FAIL reset: phase=%0d cnt=%0d got outs=%b",
               phase, instr_count,
               {fetch_en, decode_en, exec_en,
                wb_en, reg_we, busy, halted});
    end
  endtask

  task automatic test_step_latency();
    logic [4:0] got;
    logic [4:0] exp_v [6];
    exp_v = '{5'b00000, 5'b00000, 5'b10001,
              5'b01001, 5'b00101, 5'b00011};
    codop = 4'h1;
    @(negedge clk);
    step_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      got = {fetch_en, decode_en, exec_en,
             wb_en & reg_we, busy};
      checks++;
      if (got !== exp_v[i]) begin
        errors++;
        $display("FAIL step_seq[%0d]: got %b need %b",
                 i + 1, got, exp_v[i]);
      end
    end
    repeat (4) @(negedge clk);
    step_in = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (fetch_cnt !== 1 || instr_count !== 16'd1 ||
        we_cnt !== 1 || phase !== 3'd0) begin
      errors++;
      $display("FAIL held_step: fetches=%0d cnt=%0d we=%0d phase=%0d need 1 1 1 0",
               fetch_cnt, instr_count, we_cnt, phase);
    end
  endtask

  task automatic test_run_mode();
    int first = -1;
    int last = -1;
    int bad_gap = 0;
    int nfetch = 0;
    codop = 4'h2;
    do_reset();
    run = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (fetch_en) begin
        if (last >= 0 && i - last != 8) bad_gap++;
        if (first < 0) first = i;
        last = i;
        nfetch++;
      end
      if (i == 24) begin
        checks++;
        if (instr_count !== 16'd3) begin
          errors++;
          $display("FAIL run_count24: got %0d need 3",
                   instr_count);
        end
      end
    end
    checks++;
    if (first != 4 || nfetch != 4 || bad_gap != 0) begin
      errors++;
      $display("FAIL run_period: first=%0d n=%0d badgap=%0d need 4 4 0",
               first, nfetch, bad_gap);
    end
    run = 1'b0;
  endtask

  task automatic test_no_write();
    codop = 4'h9;
    do_reset();
    pulse_step();
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (wb_cnt !== 1 || we_cnt !== 0 ||
        instr_count !== 16'd1) begin
      errors++;
      $display("FAIL no_write: wb=%0d we=%0d cnt=%0d need 1 0 1",
               wb_cnt, we_cnt, instr_count);
    end
  endtask

  task automatic test_halt();
    codop = 4'hF;
    do_reset();
    pulse_step();
    wait_fetch("halt_fetch");
    @(negedge clk);
    checks++;
    if (decode_en !== 1'b1 || phase !== 3'd2) begin
      errors++;
      $display("FAIL halt_decode: phase=%0d need 2",
               phase);
    end
    @(negedge clk);
    checks++;
    if (exec_en !== 1'b1 || phase !== 3'd3) begin
      errors++;
      $display("FAIL halt_exec: phase=%0d need 3",
               phase);
    end
    @(negedge clk);
    checks++;
    if (phase !== 3'd5 || halted !== 1'b1 ||
        wb_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL halt_state: phase=%0d halted=%b wb=%b busy=%b need 5 1 0 0",
               phase, halted, wb_en, busy);
    end
    #1;
    fetch_cnt = 0;
    wb_cnt = 0;
    run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pulse_step();
      repeat (8) @(negedge clk);
    end
    #1;
    checks++;
    if (fetch_cnt !== 0 || wb_cnt !== 0 ||
        instr_count !== 16'd0 || halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_hold: fetch=%0d wb=%0d cnt=%0d halted=%b need 0 0 0 1",
               fetch_cnt, wb_cnt, instr_count, halted);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (phase !== 3'd0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset: phase=%0d halted=%b need 0 0",
               phase, halted);
    end
    rst = 1'b0;
    run = 1'b0;
  endtask

  task automatic test_step_in_exec();
    codop = 4'h1;
    do_reset();
    pulse_step();
    wait_fetch("exec_fetch");
    step_in = 1'b1;
    @(negedge clk);
    step_in = 1'b0;
    @(negedge clk);
    checks++;
    if (exec_en !== 1'b1) begin
      errors++;
      $display("FAIL exec_phase: phase=%0d need 3",
               phase);
    end
    repeat (12) @(negedge clk);
    #1;
    checks++;
    if (fetch_cnt !== 1 || instr_count !== 16'd1 ||
        phase !== 3'd0) begin
      errors++;
      $display("FAIL step_in_exec: fetches=%0d cnt=%0d phase=%0d need 1 1 0",
               fetch_cnt, instr_count, phase);
    end
  endtask

  task automatic test_reset_mid_and_wrap();
    codop = 4'h3;
    do_reset();
    pulse_step();
    repeat (10) @(negedge clk);
    checks++;
    if (instr_count !== 16'd1) begin
      errors++;
      $display("FAIL pre_mid_count: got %0d need 1",
               instr_count);
    end
    pulse_step();
    wait_fetch("mid_fetch");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (phase !== 3'd0 || instr_count !== 16'd0 ||
        {fetch_en, decode_en, exec_en, wb_en,
         reg_we, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid: phase=%0d cnt=%0d need 0 0",
               phase, instr_count);
    end
    rst = 1'b0;
    force dut.count_q = 16'hFFFF;
    @(negedge clk);
    release dut.count_q;
    @(negedge clk);
    checks++;
    if (instr_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL preload: got %h need ffff",
               instr_count);
    end
    pulse_step();
    repeat (10) @(negedge clk);
    checks++;
    if (instr_count !== 16'h0000 || phase !== 3'd0) begin
      errors++;
      $display("FAIL wrap: cnt=%h phase=%0d need 0000 0",
               instr_count, phase);
    end
  endtask

  initial begin
    codop = 4'h0;
    test_reset();
    test_step_latency();
    test_run_mode();
    test_no_write();
    test_halt();
    test_step_in_exec();
    test_reset_mid_and_wrap();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_phase_controller.md
Name: cpu_phase_controller

Overview:
Control sequencer for the four-phase multicycle datapath: fetch (switch reader), decode (register file read), execute (ALU and display latch) and writeback (register file write). It replaces the free-running phase clock generator with single-cycle phase enables on one system clock. Instructions are issued one per debounced step request, or automatically at a programmable rate in run mode. The block decodes HALT and per-opcode write permission.

Parameters:
RUN_DIV, 25000000, clk cycles spent in IDLE between instructions in run mode (must be ≥1)
HALT_OP, 4'hF, codop value that stops the processor
WB_MASK, 16'h00FF, bit i = 1 → codop i writes the register file

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
step_in  input  1  asynchronous step request, active-high (inverted KEY)
run  input  1  1 = auto-issue mode, 0 = single-step mode
codop  input  4  opcode from the fetch stage, valid from the DECODE cycle onward
fetch_en  output  1  one-cycle pulse: fetch stage captures switches
decode_en  output  1  one-cycle pulse: register file reads operands
exec_en  output  1  one-cycle pulse: ALU/display registers capture
wb_en  output  1  one-cycle pulse: writeback phase active
reg_we  output  1  register file write enable (wb_en gated by WB_MASK)
busy  output  1  1 while an instruction is in flight (FETCH..WRITEBACK)
halted  output  1  1 in HALTED state
phase  output  3  state code: 0 IDLE, 1 FETCH, 2 DECODE, 3 EXECUTE, 4 WRITEBACK, 5 HALTED
instr_count  output  16  number of completed (written-back) instructions

Behaviour:
- Reset (rst sampled 1 on an edge):
  - state → IDLE; all enables, reg_we, busy and halted = 0; phase = 0; instr_count = 0.
  - Synchronizer flops = 0; run timer reloads RUN_DIV-1.
  - Reset overrides everything, including mid-instruction and HALTED.
- Step detect:
  - step_in passes through a 2-flop synchronizer (s1, s2) plus a delayed copy s3.
  - step_pulse = s2 & ~s3.
  - Step level first sampled 1 at edge k → step_pulse valid after edge k+1 → FETCH entered at edge k+2.
  - A held step_in gives exactly one pulse.
- IDLE:
  - With run=0: go to FETCH on step_pulse.
  - With run=1: timer decrements each IDLE cycle; go to FETCH when timer==0 (IDLE lasts exactly RUN_DIV cycles). step_pulse is also accepted, whichever comes first.
  - Timer reloads RUN_DIV-1 on every entry to IDLE and while run=0.
- Phases:
  - FETCH → DECODE → EXECUTE → WRITEBACK → IDLE, one cycle each.
  - Enables are Moore outputs, high exactly while in the matching state.
  - busy = 1 in FETCH..WRITEBACK.
- Opcode latch:
  - op_q ← codop on the edge leaving DECODE.
  - Later codop changes are ignored until the next instruction.
- Writeback:
  - reg_we = wb_en & WB_MASK[op_q].
  - instr_count increments on the edge leaving WRITEBACK; wraps 16'hFFFF → 0.
- HALT:
  - If op_q == HALT_OP, EXECUTE → HALTED; WRITEBACK is skipped and instr_count is not incremented.
  - HALTED: halted=1, no enables; step and run ignored; exit only via rst.
- Step pulses arriving outside IDLE are discarded, not queued.
- Clearing run mid-instruction: the current instruction completes, then the block waits in IDLE for a step.
- Setting run while in IDLE: the timer starts from RUN_DIV-1 on the next cycle.
- Simultaneous step_pulse and timer expiry: a single FETCH is issued.

Test Plan:
1. Reset, run=0, codop=4'h1, step_in held high 10 cycles → fetch_en high on cycle 3 after first high sample; decode/exec/wb follow on cycles 4/5/6; reg_we=1 with wb_en; instr_count=1; exactly one instruction issued.
2. RUN_DIV=4, run=1, codop=4'h2 for 30 cycles → instruction every 8 cycles (4 IDLE + 4 phases); instr_count=3 after 24 cycles from reset release; fetch_en period exactly 8.
3. codop=4'h9 (WB_MASK bit 9 = 0), one step → wb_en pulses, reg_we stays 0, instr_count increments to 1.
4. codop=4'hF, one step → FETCH, DECODE, EXECUTE, then phase=5, halted=1; further steps and run=1 give no fetch_en for 50 cycles; instr_count=0; rst → phase=0, halted=0.
5. Step during EXECUTE: second step_in pulse arrives in EXECUTE → ignored; only one instruction, instr_count=1; back in IDLE.
6. rst asserted during DECODE → next cycle phase=0, all enables 0, instr_count=0; preload instr_count=16'hFFFF via 65535 runs (or force) then one step → wraps to 0.
